// File: rtl/mem_lower_pkg.sv
// Shared types and elaboration helpers for the masked 1r1w memory.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mem_lower_pkg;

   // Init walk state: CLEAR zeroes the array word by word, READY serves ports.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // Ceiling log2 with a floor of 1 so a single-word memory still has an address bit.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         res = res + 1;
      end
      return (res < 1) ? 1 : res;
   endfunction

   // Number of independently maskable lanes in one word.
   function automatic int lane_count(input int width, input int gran);
      return width / gran;
   endfunction

   // Output pipeline only exists in one- and two-register forms.
   function automatic bit read_latency_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

endpackage

// File: rtl/mem_1r1w_masked_if.sv
// Read and write port bundle of the masked 1r1w memory.
// Latency: n/a (wiring only).
// Backpressure: none; both ports accept a request every cycle.
interface mem_1r1w_masked_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int WIDTH      = 64,
   parameter int LANES      = 8
);
   logic [ADDR_WIDTH-1:0] R0_addr;
   logic                  R0_en;
   logic [WIDTH-1:0]      R0_data;
   logic [ADDR_WIDTH-1:0] W0_addr;
   logic                  W0_en;
   logic [WIDTH-1:0]      W0_data;
   logic [LANES-1:0]      W0_mask;

   modport master (
      output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
      input  R0_data
   );

   modport slave (
      input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
      output R0_data
   );
endinterface

// File: rtl/mem_1r1w_rd_pipe.sv
// Read output register chain; holds its value whenever no load reaches the output.
// Latency: READ_LATENCY cycles (1 or 2) from ld_en to rd_data.
// Backpressure: none; accepts a load every cycle, synchronous reset flushes to zero.
module mem_1r1w_rd_pipe #(
   parameter int WIDTH        = 64,
   parameter int READ_LATENCY = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ld_en,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] rd_data
);

   if (READ_LATENCY == 1) begin : g_lat1
      logic [WIDTH-1:0] data_q, data_d;

      // Capture the read word on a load, otherwise hold.
      always_comb begin
         data_d = data_q;
         if (ld_en) begin
            data_d = ld_data;
         end
      end

      // Output register.
      always_ff @(posedge clock) begin
         if (reset) begin
            data_q <= '0;
         end else begin
            data_q <= data_d;
         end
      end

      assign rd_data = data_q;
   end else begin : g_lat2
      logic [WIDTH-1:0] s1_q, s1_d;
      logic [WIDTH-1:0] s2_q, s2_d;
      logic             en_q, en_d;

      // Stage 1 loads on a request; stage 2 follows only when stage 1 was loaded last cycle.
      always_comb begin
         s1_d = s1_q;
         s2_d = s2_q;
         en_d = ld_en;
         if (ld_en) begin
            s1_d = ld_data;
         end
         if (en_q) begin
            s2_d = s1_q;
         end
      end

      // Two-stage register chain with its load-tracking flag.
      always_ff @(posedge clock) begin
         if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            en_q <= 1'b0;
         end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            en_q <= en_d;
         end
      end

      assign rd_data = s2_q;
   end

endmodule

// File: rtl/mem_1r1w_masked.sv
// Single-clock 1r1w memory with per-lane write mask, write-first bypass and zero-clear walk.
// Latency: READ_LATENCY cycles read; write visible to a same-address read in the same cycle.
// Backpressure: none; ports are ignored while init_busy is high (reset or clear walk).
module mem_1r1w_masked
   import mem_lower_pkg::*;
#(
   parameter int DEPTH          = 48,
   parameter int WIDTH          = 64,
   parameter int MASK_GRAN      = 8,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clock,
   input  logic              reset,
   mem_1r1w_masked_if.slave  mem,
   output logic              init_busy
);

   localparam int ADDR_WIDTH = clog2(DEPTH);
   localparam int LANES      = lane_count(WIDTH, MASK_GRAN);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if ((WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
      $error("mem_1r1w_masked: MASK_GRAN must divide WIDTH");
   end
   if (!read_latency_ok(READ_LATENCY)) begin : g_bad_lat
      $error("mem_1r1w_masked: READ_LATENCY must be 1 or 2");
   end

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic [WIDTH-1:0]      mem_q [DEPTH];

   logic                  wr_in_range;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [WIDTH-1:0]      wr_data;
   logic [LANES-1:0]      wr_mask;
   logic                  rd_in_range;
   logic [WIDTH-1:0]      rd_word;
   logic                  rd_ld;

   // Clear walk: step clr_cnt through every word, leave for READY after the last one.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == LAST_ADDR) begin
               state_d   = ST_READY;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // State register; reset restarts the walk from word 0 when clearing is enabled.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Write port mux: the clear walk owns the array until READY; out-of-range writes drop.
   always_comb begin
      wr_in_range = ({1'b0, mem.W0_addr} < DEPTH_EXT);
      wr_en       = 1'b0;
      wr_addr     = mem.W0_addr;
      wr_data     = mem.W0_data;
      wr_mask     = mem.W0_mask;
      if (state_q == ST_CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = clr_cnt_q;
         wr_data = '0;
         wr_mask = '1;
      end else begin
         wr_en = mem.W0_en && wr_in_range;
      end
      if (reset) begin
         wr_en = 1'b0;
      end
   end

   // Storage array with lane enables; no reset so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (wr_mask[i]) begin
               mem_q[wr_addr][i*MASK_GRAN +: MASK_GRAN] <= wr_data[i*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

   // Read word: zero for out-of-range, write-first bypass on lanes written this cycle.
   always_comb begin
      rd_in_range = ({1'b0, mem.R0_addr} < DEPTH_EXT);
      rd_word     = '0;
      if (rd_in_range) begin
         rd_word = mem_q[mem.R0_addr];
         for (int i = 0; i < LANES; i++) begin
            if (wr_en && (wr_addr == mem.R0_addr) && wr_mask[i]) begin
               rd_word[i*MASK_GRAN +: MASK_GRAN] = wr_data[i*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
      rd_ld = (state_q == ST_READY) && mem.R0_en;
   end

   mem_1r1w_rd_pipe #(
      .WIDTH        (WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clock   (clock),
      .reset   (reset),
      .ld_en   (rd_ld),
      .ld_data (rd_word),
      .rd_data (mem.R0_data)
   );

   assign init_busy = reset || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mem_1r1w_masked.sv
// Bench for the masked 1r1w memory: latency-1 instance plus a latency-2 instance.
// Latency: expectations queued at request time, popped when the read data is due.
// Backpressure: n/a.
module tb_mem_1r1w_masked;

   logic clock = 1'b0;
   logic reset;
   logic init_busy;
   logic init_busy2;

   int errors = 0;
   int checks = 0;
   logic [63:0] sb_q [$];

   always #5 clock = ~clock;

   mem_1r1w_masked_if #(.ADDR_WIDTH(6), .WIDTH(64), .LANES(8)) m_if ();
   mem_1r1w_masked_if #(.ADDR_WIDTH(6), .WIDTH(64), .LANES(8)) if2 ();

   mem_1r1w_masked #(
      .DEPTH(48), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .mem       (m_if.slave),
      .init_busy (init_busy)
   );

   mem_1r1w_masked #(
      .DEPTH(48), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
   ) dut2 (
      .clock     (clock),
      .reset     (reset),
      .mem       (if2.slave),
      .init_busy (init_busy2)
   );

   task automatic drv_write(input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
      m_if.W0_en   = 1'b1;
      m_if.W0_addr = a;
      m_if.W0_data = d;
      m_if.W0_mask = m;
      @(posedge clock);
      #1;
      m_if.W0_en = 1'b0;
   endtask

   task automatic drv_read(input logic [5:0] a, input logic [63:0] e);
      sb_q.push_back(e);
      m_if.R0_en   = 1'b1;
      m_if.R0_addr = a;
      @(posedge clock);
      #1;
      m_if.R0_en = 1'b0;
   endtask

   task automatic test_reset();
      int busy_cnt;
      int nz;
      logic [63:0] e;
      busy_cnt = 0;
      nz = 0;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (init_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_in_reset: got %b want 1", init_busy);
      end
      checks++;
      if (m_if.R0_data !== 64'h0) begin
         errors++;
         $display("FAIL data_in_reset: got %h want 0", m_if.R0_data);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (!init_busy) break;
         busy_cnt++;
         if (m_if.R0_data !== 64'h0) nz++;
      end
      checks++;
      if (busy_cnt != 48) begin
         errors++;
         $display("FAIL busy_len: got %0d want 48", busy_cnt);
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL data_zero_clear: got %0d nonzero samples want 0", nz);
      end
      drv_read(6'd47, 64'h0);
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL read_47: got %h want %h", m_if.R0_data, e);
      end
   endtask

   task automatic test_masked_write();
      logic [63:0] e;
      drv_write(6'd5, 64'h1122334455667788, 8'hFF);
      drv_write(6'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      drv_read(6'd5, 64'h11223344AAAAAAAA);
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL masked_write: got %h want %h", m_if.R0_data, e);
      end
   endtask

   task automatic test_rdw_bypass();
      logic [63:0] e;
      // same address, same cycle
      m_if.W0_en   = 1'b1;
      m_if.W0_addr = 6'd9;
      m_if.W0_data = 64'hFFFFFFFFFFFFFFFF;
      m_if.W0_mask = 8'h03;
      sb_q.push_back(64'h000000000000FFFF);
      m_if.R0_en   = 1'b1;
      m_if.R0_addr = 6'd9;
      @(posedge clock);
      #1;
      m_if.W0_en = 1'b0;
      m_if.R0_en = 1'b0;
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL rdw_same: got %h want %h", m_if.R0_data, e);
      end
      // different addresses do not interact
      m_if.W0_en   = 1'b1;
      m_if.W0_addr = 6'd12;
      m_if.W0_data = 64'h123456789ABCDEF0;
      m_if.W0_mask = 8'hFF;
      sb_q.push_back(64'h000000000000FFFF);
      m_if.R0_en   = 1'b1;
      m_if.R0_addr = 6'd9;
      @(posedge clock);
      #1;
      m_if.W0_en = 1'b0;
      m_if.R0_en = 1'b0;
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL rdw_diff: got %h want %h", m_if.R0_data, e);
      end
      drv_read(6'd9, 64'h000000000000FFFF);
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL rdw_reread: got %h want %h", m_if.R0_data, e);
      end
   endtask

   task automatic test_range_hold();
      logic [63:0] e;
      logic [63:0] hold_v;
      hold_v = 64'h11223344AAAAAAAA;
      drv_read(6'd5, hold_v);
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL read_5: got %h want %h", m_if.R0_data, e);
      end
      drv_write(6'd50, 64'h1, 8'hFF);
      drv_read(6'd50, 64'h0);
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL read_oor: got %h want %h", m_if.R0_data, e);
      end
      drv_read(6'd5, hold_v);
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL read_5_again: got %h want %h", m_if.R0_data, e);
      end
      for (int i = 0; i < 5; i++) begin
         m_if.R0_addr = 6'(i + 9);
         @(negedge clock);
         checks++;
         if (m_if.R0_data !== hold_v) begin
            errors++;
            $display("FAIL hold_%0d: got %h want %h", i, m_if.R0_data, hold_v);
         end
      end
   endtask

   task automatic test_latency2();
      logic [63:0] e;
      logic [63:0] last_v;
      for (int k = 1; k <= 3; k++) begin
         if2.W0_en   = 1'b1;
         if2.W0_addr = 6'(k);
         if2.W0_data = 64'(k);
         if2.W0_mask = 8'hFF;
         @(posedge clock);
         #1;
      end
      if2.W0_en = 1'b0;
      checks++;
      if (init_busy2 !== 1'b0) begin
         errors++;
         $display("FAIL lat2_busy: got %b want 0", init_busy2);
      end
      last_v = 64'h3;
      for (int k = 0; k < 6; k++) begin
         if (k < 3) begin
            if2.R0_en   = 1'b1;
            if2.R0_addr = 6'(k + 1);
            sb_q.push_back(64'(k + 1));
         end else begin
            if2.R0_en = 1'b0;
         end
         @(posedge clock);
         #1;
         @(negedge clock);
         if (k == 0) begin
            checks++;
            if (if2.R0_data !== 64'h0) begin
               errors++;
               $display("FAIL lat2_early: got %h want 0", if2.R0_data);
            end
         end else if (k <= 3) begin
            e = sb_q.pop_front();
            checks++;
            if (if2.R0_data !== e) begin
               errors++;
               $display("FAIL lat2_read_%0d: got %h want %h", k, if2.R0_data, e);
            end
         end else begin
            checks++;
            if (if2.R0_data !== last_v) begin
               errors++;
               $display("FAIL lat2_hold_%0d: got %h want %h", k, if2.R0_data, last_v);
            end
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      int busy_cnt;
      int nz;
      logic [63:0] e;
      busy_cnt = 0;
      nz = 0;
      drv_write(6'd40, 64'hDEADBEEFCAFEF00D, 8'hFF);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      m_if.R0_en   = 1'b1;
      m_if.R0_addr = 6'd40;
      repeat (20) begin
         @(negedge clock);
         if (m_if.R0_data !== 64'h0) nz++;
         @(posedge clock);
         #1;
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (init_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_mid_reset: got %b want 1", init_busy);
      end
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         m_if.W0_en = 1'b0;
         if (!init_busy) break;
         busy_cnt++;
         if (m_if.R0_data !== 64'h0) nz++;
         if (busy_cnt == 12) begin
            m_if.W0_en   = 1'b1;
            m_if.W0_addr = 6'd3;
            m_if.W0_data = 64'hFFFFFFFFFFFFFFFF;
            m_if.W0_mask = 8'hFF;
         end
      end
      m_if.R0_en = 1'b0;
      m_if.W0_en = 1'b0;
      checks++;
      if (busy_cnt != 48) begin
         errors++;
         $display("FAIL busy_len_restart: got %0d want 48", busy_cnt);
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL data_zero_restart: got %0d nonzero samples want 0", nz);
      end
      drv_read(6'd3, 64'h0);
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL write_in_clear: got %h want %h", m_if.R0_data, e);
      end
      drv_read(6'd40, 64'h0);
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL cleared_40: got %h want %h", m_if.R0_data, e);
      end
      drv_read(6'd9, 64'h0);
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (m_if.R0_data !== e) begin
         errors++;
         $display("FAIL cleared_9: got %h want %h", m_if.R0_data, e);
      end
   endtask

   initial begin
      reset        = 1'b1;
      m_if.R0_en   = 1'b0;
      m_if.R0_addr = '0;
      m_if.W0_en   = 1'b0;
      m_if.W0_addr = '0;
      m_if.W0_data = '0;
      m_if.W0_mask = '0;
      if2.R0_en    = 1'b0;
      if2.R0_addr  = '0;
      if2.W0_en    = 1'b0;
      if2.W0_addr  = '0;
      if2.W0_data  = '0;
      if2.W0_mask  = '0;
      test_reset();
      test_masked_write();
      test_rdw_bypass();
      test_range_hold();
      test_latency2();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/mem_1r1w_masked.md
Name: mem_1r1w_masked

Overview:
- Parametrised single-clock successor of the plain 1r1w memory macro.
- Adds per-lane write mask, write-first read-during-write bypass, selectable read latency (1 or 2) and an optional hardware zero-clear after reset.
- Sits where generated SRAM wrappers sit: behind Chisel-lowered memory ports, feeding caches and queues that need masked writes and deterministic initial contents.

Parameters:
- DEPTH, 48: number of words.
- WIDTH, 64: bits per word.
- MASK_GRAN, 8: bits per mask lane. Must divide WIDTH, else elaboration error. MASK_GRAN=WIDTH gives a 1-bit mask.
- READ_LATENCY, 1: cycles from R0_en to R0_data. Legal values are 1 or 2 only.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents undefined after reset.
- ADDR_WIDTH, clog2(DEPTH) (minimum 1): derived, not to be overridden.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- R0_addr  in  ADDR_WIDTH  read address.
- R0_en  in  1  read enable.
- R0_data  out  WIDTH  read data.
- W0_addr  in  ADDR_WIDTH  write address.
- W0_en  in  1  write enable.
- W0_data  in  WIDTH  write data.
- W0_mask  in  WIDTH/MASK_GRAN  lane i enables bits [i*MASK_GRAN +: MASK_GRAN].
- init_busy  out  1  high while reset is asserted or clear is in progress.

Behaviour:
- One clock; reset is synchronous and active-high.
- FSM states: CLEAR, READY.
  - Reset → CLEAR if CLEAR_ON_RESET=1, else READY.
  - CLEAR: writes zero to clr_cnt each cycle, clr_cnt 0..DEPTH-1. Goes to READY in the cycle after writing DEPTH-1. CLEAR lasts exactly DEPTH cycles after reset deasserts.
- Reset values:
  - R0_data = 0.
  - All read-pipeline registers and enables = 0.
  - clr_cnt = 0.
  - init_busy = 1 during reset, then 1 for DEPTH cycles (CLEAR_ON_RESET=1) or 0 (CLEAR_ON_RESET=0).
- During CLEAR: W0_en and R0_en are ignored; R0_data holds 0.
- Write (READY, W0_en=1):
  - Updates only lanes with W0_mask[i]=1; other lanes keep old contents.
  - W0_addr >= DEPTH: write dropped silently.
- Read (READY, R0_en=1): word sampled at the clock edge.
  - READY_LATENCY=1: R0_data valid from the next cycle.
  - READ_LATENCY=2: stage-1 register s1 loads on R0_en; en_d <= R0_en; stage-2 loads s1 when en_d=1; R0_data = stage 2.
  - R0_addr >= DEPTH: returns all zeros.
- Hold: when no load occurs, R0_data keeps its last value. No spontaneous change on R0_en=0.
- Read-during-write, same address, same cycle (write-first):
  - Masked lanes return new W0_data.
  - Unmasked lanes return old contents.
  - Different addresses: no interaction.
- Reset mid-operation (including mid-CLEAR):
  - Pipeline flushed, R0_data = 0.
  - clr_cnt restarts at 0; full DEPTH-cycle clear after release.
  - Memory contents not reset except through the CLEAR walk.
- Storage: behavioural array, inferable as block RAM. Bypass and out-of-range zeroing are done in muxes ahead of the stage-1 register.

Decomposition:
- Package mem_lower_pkg:
  - state enum {ST_CLEAR, ST_READY}
  - clog2 function
  - lane-count helper (WIDTH/MASK_GRAN)
  - READ_LATENCY legality check
- Sub-module mem_1r1w_rd_pipe: READ_LATENCY-stage output pipeline with enables and synchronous reset; instantiated once.

Test Plan (DEPTH=48, WIDTH=64, MASK_GRAN=8, READ_LATENCY=1 unless noted):
1. Reset high 2 cycles, then release → init_busy high for exactly 48 cycles after release, then low; read addr 47 → 0x0000000000000000.
2. Write addr 5 = 0x1122334455667788 mask 0xFF, then addr 5 = 0xAAAAAAAAAAAAAAAA mask 0x0F, read addr 5 → 0x11223344AAAAAAAA one cycle after R0_en.
3. Addr 9 holds 0; same cycle write addr 9 0xFFFFFFFFFFFFFFFF mask 0x03 and read addr 9 → next cycle 0x000000000000FFFF. Next read of addr 9 → same value.
4. Write addr 50 = 0x1 then read addr 50 → 0; R0_en low for 5 cycles → R0_data unchanged; W0_en pulses during CLEAR → addr stays 0 after init_busy falls.
5. READ_LATENCY=2: back-to-back reads of addrs 1,2,3 holding 0x1,0x2,0x3 → R0_data = 0x1,0x2,0x3 on cycles +2,+3,+4.
6. Reset asserted when clr_cnt=20 → after release init_busy high exactly 48 cycles; R0_data = 0 throughout.
